encode_mul_pipe_mac: RTL and testbench

//  Parametrised pipelined multiplier / multiply-accumulate for the encoder datapath.

---
 rtl/encode_mul_pipe_mac_if.sv | 41 ++++
 rtl/encode_mul_pipe_mac.sv | 128 ++++++++++++
 tb/tb_encode_mul_pipe_mac.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encode_mul_pipe_mac_if.sv
// Beat bundle between encoder fetch, the MAC datapath and the quantiser.
// Master issues beats and owns the stall; slave is the MAC.
interface encode_mul_pipe_mac_if #(
    parameter int DIN0_WIDTH = 40,
    parameter int DIN1_WIDTH = 33,
    parameter int DOUT_WIDTH = 70
);
    logic                  ce;
    logic                  in_valid;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  acc_en;
    logic                  acc_clr;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  sat;

    modport master (
        output ce,
        output in_valid,
        output din0,
        output din1,
        output acc_en,
        output acc_clr,
        input  out_valid,
        input  dout,
        input  sat
    );

    modport slave (
        input  ce,
        input  in_valid,
        input  din0,
        input  din1,
        input  acc_en,
        input  acc_clr,
        output out_valid,
        output dout,
        output sat
    );
endinterface

// File: rtl/encode_mul_pipe_mac.sv
// Pipelined multiply / multiply-accumulate for the encoder datapath,
// with round-half-up scaling and signed output saturation.
module encode_mul_pipe_mac #(
    parameter int DIN0_WIDTH = 40,
    parameter int DIN1_WIDTH = 33,
    parameter bit SIGNED0    = 1'b1,
    parameter bit SIGNED1    = 1'b1,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 80,
    parameter int SHIFT      = 0,
    parameter int DOUT_WIDTH = 70
) (
    input logic                  clk,
    input logic                  reset,
    encode_mul_pipe_mac_if.slave bus
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int RW = ACC_WIDTH + 1;
    localparam int CW = ((RW > DOUT_WIDTH) ? RW : DOUT_WIDTH) + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << RS) : '0;
    localparam logic signed [CW-1:0] DMAX =
        (CW'(1) << (DOUT_WIDTH - 1)) - CW'(1);
    localparam logic signed [CW-1:0] DMIN = -DMAX - CW'(1);

    typedef struct packed {
        logic          vld;
        logic          en;
        logic          clr;
        logic [PW-1:0] p;
    } beat_t;

    logic signed [DIN0_WIDTH:0] a_x;
    logic signed [DIN1_WIDTH:0] b_x;
    beat_t                      s0;
    beat_t                      fin;

    always_comb begin
        a_x = {SIGNED0 ? bus.din0[DIN0_WIDTH-1] : 1'b0, bus.din0};
        b_x = {SIGNED1 ? bus.din1[DIN1_WIDTH-1] : 1'b0, bus.din1};
        s0.vld = bus.in_valid;
        s0.en  = bus.acc_en;
        s0.clr = bus.acc_clr;
        s0.p   = PW'(a_x) * PW'(b_x);
    end

    // Product and sideband move together; the last stage is the output reg.
    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign fin = s0;
        end else begin : g_pipe
            beat_t pipe_q [NUM_STAGE-1];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < NUM_STAGE - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else if (bus.ce) begin
                    pipe_q[0] <= s0;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign fin = pipe_q[NUM_STAGE-2];
        end
    endgenerate

    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic signed [ACC_WIDTH-1:0]  p_x;
    logic signed [ACC_WIDTH-1:0]  v;
    logic signed [RW-1:0]         r;
    logic signed [CW-1:0]         r_x;
    logic        [DOUT_WIDTH-1:0] dout_q;
    logic        [DOUT_WIDTH-1:0] dout_d;
    logic                         sat_q;
    logic                         sat_d;
    logic                         out_valid_q;

    always_comb begin
        p_x = ACC_WIDTH'($signed(fin.p));
        v   = p_x;
        if (!fin.clr && fin.en) begin
            v = acc_q + p_x;
        end
        acc_d = acc_q;
        if (fin.vld && (fin.clr || fin.en)) begin
            acc_d = v;
        end
        // One extra bit keeps the rounding add from overflowing.
        r      = (RW'(v) + RND) >>> SHIFT;
        r_x    = CW'(r);
        sat_d  = 1'b0;
        dout_d = r_x[DOUT_WIDTH-1:0];
        if (r_x > DMAX) begin
            dout_d = DMAX[DOUT_WIDTH-1:0];
            sat_d  = 1'b1;
        end else if (r_x < DMIN) begin
            dout_d = DMIN[DOUT_WIDTH-1:0];
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.ce) begin
            out_valid_q <= fin.vld;
            acc_q       <= acc_d;
            if (fin.vld) begin
                dout_q <= dout_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_encode_mul_pipe_mac.sv
// Scoreboard bench for encode_mul_pipe_mac across several parameter sets.
// Expected results are queued at issue time and popped on out_valid.
module tb_encode_mul_pipe_mac;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    exp_t q_d[$];
    exp_t q_s[$];
    exp_t q_u[$];
    exp_t q_v[$];
    exp_t q_q[$];

    encode_mul_pipe_mac_if #(.DIN0_WIDTH(40), .DIN1_WIDTH(33), .DOUT_WIDTH(70)) if_d();
    encode_mul_pipe_mac_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8)) if_s();
    encode_mul_pipe_mac_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(20)) if_u();
    encode_mul_pipe_mac_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(20)) if_v();
    encode_mul_pipe_mac_if #(.DIN0_WIDTH(40), .DIN1_WIDTH(33), .DOUT_WIDTH(70)) if_q();

    encode_mul_pipe_mac u_d (
        .clk(clk), .reset(rst_n), .bus(if_d)
    );

    encode_mul_pipe_mac #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .SIGNED0(1'b1), .SIGNED1(1'b1),
        .NUM_STAGE(2), .ACC_WIDTH(17), .SHIFT(4), .DOUT_WIDTH(8)
    ) u_s (
        .clk(clk), .reset(rst_n), .bus(if_s)
    );

    encode_mul_pipe_mac #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .SIGNED0(1'b0), .SIGNED1(1'b1),
        .NUM_STAGE(1), .ACC_WIDTH(17), .SHIFT(0), .DOUT_WIDTH(20)
    ) u_u (
        .clk(clk), .reset(rst_n), .bus(if_u)
    );

    encode_mul_pipe_mac #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .SIGNED0(1'b1), .SIGNED1(1'b1),
        .NUM_STAGE(3), .ACC_WIDTH(17), .SHIFT(0), .DOUT_WIDTH(20)
    ) u_v (
        .clk(clk), .reset(rst_n), .bus(if_v)
    );

    encode_mul_pipe_mac #(
        .DIN0_WIDTH(40), .DIN1_WIDTH(33), .SIGNED0(1'b1), .SIGNED1(1'b1),
        .NUM_STAGE(4), .ACC_WIDTH(80), .SHIFT(0), .DOUT_WIDTH(70)
    ) u_q (
        .clk(clk), .reset(rst_n), .bus(if_q)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        if_d.in_valid = 1'b1;
        if_d.din0 = 40'd9;
        if_d.din1 = 33'd9;
        repeat (3) @(negedge clk);
        checks++;
        if (if_d.out_valid !== 1'b0 || if_d.dout !== '0 || if_d.sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ov=%b dout=%0d sat=%b exp 0/0/0", if_d.out_valid, $signed(if_d.dout), if_d.sat);
        end
        checks++;
        if (if_s.dout !== '0 || if_u.dout !== '0 || if_v.dout !== '0 || if_q.dout !== '0) begin
            failures++;
            $display("FAIL reset_others s=%0d u=%0d v=%0d q=%0d exp 0", if_s.dout, if_u.dout, if_v.dout, if_q.dout);
        end
        if_d.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if_d.out_valid !== 1'b0 || if_q.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ov_d=%b ov_q=%b exp 0", if_d.out_valid, if_q.out_valid);
        end
    endtask

    task automatic test_defaults();
        exp_t   e;
        longint a = -3;
        longint b = 5;
        @(negedge clk);
        if_d.in_valid = 1'b1;
        if_d.din0 = 40'(a);
        if_d.din1 = 33'(b);
        if_d.acc_en = 1'b0;
        if_d.acc_clr = 1'b0;
        q_d.push_back('{d: a * b, s: 1'b0});
        @(negedge clk);
        if_d.in_valid = 1'b0;
        checks++;
        if (if_d.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL defaults_early ov=%b exp 0", if_d.out_valid);
        end
        @(negedge clk);
        e = q_d.pop_front();
        checks++;
        if (if_d.out_valid !== 1'b1 || if_d.dout !== 70'(e.d) || if_d.sat !== e.s) begin
            failures++;
            $display("FAIL defaults_result ov=%b dout=%0d sat=%b exp 1/%0d/%b", if_d.out_valid, $signed(if_d.dout), if_d.sat, e.d, e.s);
        end
        @(negedge clk);
        checks++;
        if (if_d.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL defaults_one_cycle ov=%b exp 0", if_d.out_valid);
        end
    endtask

    task automatic test_stall();
        exp_t   e;
        longint prev = -15;
        @(negedge clk);
        if_d.in_valid = 1'b1;
        if_d.din0 = 40'd7;
        if_d.din1 = 33'd6;
        q_d.push_back('{d: 42, s: 1'b0});
        @(negedge clk);
        if_d.in_valid = 1'b0;
        if_d.ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (if_d.out_valid !== 1'b0 || if_d.dout !== 70'(prev)) begin
                failures++;
                $display("FAIL stall_frozen%0d ov=%b dout=%0d exp 0/%0d", k, if_d.out_valid, $signed(if_d.dout), prev);
            end
        end
        if_d.ce = 1'b1;
        @(negedge clk);
        e = q_d.pop_front();
        checks++;
        if (if_d.out_valid !== 1'b1 || if_d.dout !== 70'(e.d) || if_d.sat !== e.s) begin
            failures++;
            $display("FAIL stall_result ov=%b dout=%0d exp 1/%0d", if_d.out_valid, $signed(if_d.dout), e.d);
        end
        if_d.ce = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if_d.out_valid !== 1'b1 || if_d.dout !== 70'(e.d)) begin
            failures++;
            $display("FAIL stall_hold_valid ov=%b dout=%0d exp 1/%0d", if_d.out_valid, $signed(if_d.dout), e.d);
        end
        if_d.ce = 1'b1;
        @(negedge clk);
        checks++;
        if (if_d.out_valid !== 1'b0 || if_d.dout !== 70'(e.d)) begin
            failures++;
            $display("FAIL stall_drop ov=%b dout=%0d exp 0/%0d", if_d.out_valid, $signed(if_d.dout), e.d);
        end
    endtask

    task automatic test_scale();
        int sa[11] = '{100, 7, -7, -100, 8, -8, -24, 127, 127, -128, -128};
        int sb[11] = '{100, 9, 9, 100, 1, 1, 1, 16, 17, 16, 17};
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    longint p;
                    longint r;
                    exp_t   x;
                    @(negedge clk);
                    if_s.in_valid = 1'b1;
                    if_s.din0 = 8'(sa[i]);
                    if_s.din1 = 8'(sb[i]);
                    p = longint'(sa[i]) * longint'(sb[i]);
                    r = (p + 8) >>> 4;
                    x.s = 1'b0;
                    x.d = r;
                    if (r > 127) begin
                        x.d = 127;
                        x.s = 1'b1;
                    end else if (r < -128) begin
                        x.d = -128;
                        x.s = 1'b1;
                    end
                    q_s.push_back(x);
                end
                @(negedge clk);
                if_s.in_valid = 1'b0;
            end
            begin
                int   got = 0;
                int   cyc = 0;
                exp_t e;
                while (got < 11 && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                    if (if_s.out_valid === 1'b1) begin
                        checks++;
                        if (q_s.size() == 0) begin
                            failures++;
                            $display("FAIL scale_extra dout=%0d exp none", $signed(if_s.dout));
                        end else begin
                            e = q_s.pop_front();
                            if (if_s.dout !== 8'(e.d) || if_s.sat !== e.s) begin
                                failures++;
                                $display("FAIL scale_beat%0d dout=%0d sat=%b exp %0d/%b", got, $signed(if_s.dout), if_s.sat, e.d, e.s);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got < 11) begin
                    failures++;
                    $display("FAIL scale_timeout got=%0d exp 11", got);
                end
            end
        join
    endtask

    task automatic test_mac();
        bit     tv[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        bit     tc[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
        bit     te[8] = '{0, 1, 1, 1, 0, 1, 1, 1};
        int     ta[8] = '{2, 4, 1, 50, 10, 1, -3, -2};
        int     tb[8] = '{3, 5, -1, 50, 10, 1, 4, -2};
        int     nv = 7;
        fork
            begin
                longint acc_m = 0;
                for (int i = 0; i < 8; i++) begin
                    longint p;
                    longint v;
                    @(negedge clk);
                    if_d.in_valid = tv[i];
                    if_d.acc_clr = tc[i];
                    if_d.acc_en = te[i];
                    if_d.din0 = 40'(ta[i]);
                    if_d.din1 = 33'(tb[i]);
                    if (tv[i]) begin
                        p = longint'(ta[i]) * longint'(tb[i]);
                        v = tc[i] ? p : (te[i] ? acc_m + p : p);
                        if (tc[i] || te[i]) acc_m = v;
                        q_d.push_back('{d: v, s: 1'b0});
                    end
                end
                @(negedge clk);
                if_d.in_valid = 1'b0;
                if_d.acc_clr = 1'b0;
                if_d.acc_en = 1'b0;
            end
            begin
                int   got = 0;
                int   cyc = 0;
                exp_t e;
                while (got < nv && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                    if (if_d.out_valid === 1'b1) begin
                        checks++;
                        if (q_d.size() == 0) begin
                            failures++;
                            $display("FAIL mac_extra dout=%0d exp none", $signed(if_d.dout));
                        end else begin
                            e = q_d.pop_front();
                            if (if_d.dout !== 70'(e.d) || if_d.sat !== e.s) begin
                                failures++;
                                $display("FAIL mac_beat%0d dout=%0d sat=%b exp %0d/%b", got, $signed(if_d.dout), if_d.sat, e.d, e.s);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got < nv) begin
                    failures++;
                    $display("FAIL mac_timeout got=%0d exp %0d", got, nv);
                end
            end
        join
    endtask

    task automatic test_signedness();
        logic [7:0] ta[5] = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h00};
        logic [7:0] tb[5] = '{8'h02, 8'hFF, 8'h80, 8'h80, 8'h55};
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    logic [7:0] a;
                    logic [7:0] b;
                    a = ta[i];
                    b = tb[i];
                    @(negedge clk);
                    if_u.in_valid = 1'b1;
                    if_v.in_valid = 1'b1;
                    if_u.din0 = a;
                    if_u.din1 = b;
                    if_v.din0 = a;
                    if_v.din1 = b;
                    q_u.push_back('{d: longint'(int'(a) * int'($signed(b))), s: 1'b0});
                    q_v.push_back('{d: longint'(int'($signed(a)) * int'($signed(b))), s: 1'b0});
                end
                @(negedge clk);
                if_u.in_valid = 1'b0;
                if_v.in_valid = 1'b0;
            end
            begin
                int   got = 0;
                int   cyc = 0;
                exp_t e;
                while (got < 5 && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                    if (if_u.out_valid === 1'b1) begin
                        checks++;
                        if (q_u.size() == 0) begin
                            failures++;
                            $display("FAIL unsigned_extra dout=%0d exp none", $signed(if_u.dout));
                        end else begin
                            e = q_u.pop_front();
                            if (if_u.dout !== 20'(e.d) || if_u.sat !== e.s) begin
                                failures++;
                                $display("FAIL unsigned_beat%0d dout=%0d exp %0d", got, $signed(if_u.dout), e.d);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got < 5) begin
                    failures++;
                    $display("FAIL unsigned_timeout got=%0d exp 5", got);
                end
            end
            begin
                int   got = 0;
                int   cyc = 0;
                exp_t e;
                while (got < 5 && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                    if (if_v.out_valid === 1'b1) begin
                        checks++;
                        if (q_v.size() == 0) begin
                            failures++;
                            $display("FAIL signed_extra dout=%0d exp none", $signed(if_v.dout));
                        end else begin
                            e = q_v.pop_front();
                            if (if_v.dout !== 20'(e.d) || if_v.sat !== e.s) begin
                                failures++;
                                $display("FAIL signed_beat%0d dout=%0d exp %0d", got, $signed(if_v.dout), e.d);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got < 5) begin
                    failures++;
                    $display("FAIL signed_timeout got=%0d exp 5", got);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        int   got = 0;
        int   spurious = 0;
        exp_t e;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (if_q.out_valid === 1'b1) begin
                checks++;
                if (q_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra dout=%0d exp none", $signed(if_q.dout));
                end else begin
                    e = q_q.pop_front();
                    if (if_q.dout !== 70'(e.d) || if_q.sat !== e.s) begin
                        failures++;
                        $display("FAIL b2b_beat%0d dout=%0d exp %0d", got, $signed(if_q.dout), e.d);
                    end
                end
                got++;
            end
            if_q.in_valid = 1'b1;
            if_q.din0 = 40'(j);
            if_q.din1 = 33'(j + 1);
            q_q.push_back('{d: longint'(j) * longint'(j + 1), s: 1'b0});
        end
        checks++;
        if (got != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp 3", got);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if_q.out_valid !== 1'b0 || if_q.dout !== '0 || if_q.sat !== 1'b0) begin
            failures++;
            $display("FAIL b2b_async_reset ov=%b dout=%0d sat=%b exp 0/0/0", if_q.out_valid, $signed(if_q.dout), if_q.sat);
        end
        @(negedge clk);
        if_q.din0 = 40'd7;
        if_q.din1 = 33'd8;
        @(negedge clk);
        if_q.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        q_q.delete();
        repeat (12) begin
            @(negedge clk);
            if (if_q.out_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL b2b_after_release spurious=%0d exp 0", spurious);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        if_d.ce = 1'b1; if_d.in_valid = 1'b0; if_d.din0 = '0; if_d.din1 = '0;
        if_d.acc_en = 1'b0; if_d.acc_clr = 1'b0;
        if_s.ce = 1'b1; if_s.in_valid = 1'b0; if_s.din0 = '0; if_s.din1 = '0;
        if_s.acc_en = 1'b0; if_s.acc_clr = 1'b0;
        if_u.ce = 1'b1; if_u.in_valid = 1'b0; if_u.din0 = '0; if_u.din1 = '0;
        if_u.acc_en = 1'b0; if_u.acc_clr = 1'b0;
        if_v.ce = 1'b1; if_v.in_valid = 1'b0; if_v.din0 = '0; if_v.din1 = '0;
        if_v.acc_en = 1'b0; if_v.acc_clr = 1'b0;
        if_q.ce = 1'b1; if_q.in_valid = 1'b0; if_q.din0 = '0; if_q.din1 = '0;
        if_q.acc_en = 1'b0; if_q.acc_clr = 1'b0;
        test_reset();
        test_defaults();
        test_stall();
        test_scale();
        test_mac();
        test_signedness();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
